// File: rtl/section_select_pkg.sv
`default_nettype none
// ============================================================================
// section_select_pkg : shared word layout and config-select encodings
// Rev 1.0
// ============================================================================
package section_select_pkg;

   localparam int NUM_WORD = 13;

   localparam int COEF0  = 0;
   localparam int COEF1  = 1;
   localparam int COEF2  = 2;
   localparam int COEF3  = 3;
   localparam int COEF4  = 4;
   localparam int COEF5  = 5;
   localparam int COEF6  = 6;
   localparam int COEF7  = 7;
   localparam int COEF8  = 8;
   localparam int COEF9  = 9;
   localparam int COEF10 = 10;
   localparam int MEAN   = 11;
   localparam int STD    = 12;

   localparam logic CFG_SEL_BANK = 1'b0;
   localparam logic CFG_SEL_BND  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/section_index.sv
`default_nettype none
// ============================================================================
// section_index : counts boundaries at or below a signed sample (section id)
// Rev 1.0
// ============================================================================
module section_index
   import section_select_pkg::*;
#(
   parameter int X_W       = 21,
   parameter int NUM_SECT  = 4,
   localparam int SECT_W   = $clog2(NUM_SECT)
) (
   input  logic [X_W-1:0]                x,
   input  logic [NUM_SECT-2:0][X_W-1:0]  bnd,
   output logic [SECT_W-1:0]             sect
);

   // A plain count rather than a priority search, so unsorted boundaries still give a defined result.
   always_comb begin
      sect = '0;
      for (int i = 0; i < NUM_SECT - 1; i++) begin
         if ($signed(x) >= $signed(bnd[i])) begin
            sect = sect + SECT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/section_select.sv
`default_nettype none
// ============================================================================
// section_select : two-stage pipeline tagging each sample with its section
//                  index and that section's coefficient words
// Rev 1.0
// ============================================================================
module section_select
   import section_select_pkg::*;
#(
   parameter int NUM_SECT  = 4,
   parameter int X_W       = 21,
   parameter int COEFF_W   = 32,
   parameter int NUM_WORD  = section_select_pkg::NUM_WORD,
   localparam int SECT_W   = $clog2(NUM_SECT),
   localparam int WORD_W   = $clog2(NUM_WORD)
) (
   input  logic                          Clock,
   input  logic                          GlobalReset,
   input  logic                          cfg_we,
   input  logic                          cfg_sel,
   input  logic [SECT_W-1:0]             cfg_sect,
   input  logic [WORD_W-1:0]             cfg_word,
   input  logic [COEFF_W-1:0]            cfg_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [X_W-1:0]                x_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [X_W-1:0]                out_x,
   output logic [SECT_W-1:0]             out_sect,
   output logic [NUM_WORD*COEFF_W-1:0]   out_coeff,
   output logic [15:0]                   sample_cnt
);

   logic [NUM_SECT-2:0][X_W-1:0]  bnd_q, bnd_d;
   logic [COEFF_W-1:0]            bank_q [NUM_SECT][NUM_WORD];
   logic [COEFF_W-1:0]            bank_d [NUM_SECT][NUM_WORD];

   logic                          s1_valid_q, s1_valid_d;
   logic [X_W-1:0]                s1_x_q, s1_x_d;
   logic [SECT_W-1:0]             s1_sect_q, s1_sect_d;

   logic                          out_valid_q, out_valid_d;
   logic [X_W-1:0]                out_x_q, out_x_d;
   logic [SECT_W-1:0]             out_sect_q, out_sect_d;
   logic [NUM_WORD*COEFF_W-1:0]   out_coeff_q, out_coeff_d;
   logic [15:0]                   sample_cnt_q, sample_cnt_d;

   logic [SECT_W-1:0]             sect_w;
   logic                          s2_load;
   logic                          accept;
   logic                          bank_ok;
   logic                          bnd_ok;

   section_index #(
      .X_W      (X_W),
      .NUM_SECT (NUM_SECT)
   ) u_section_index (
      .x    (x_in),
      .bnd  (bnd_q),
      .sect (sect_w)
   );

   assign s2_load  = !out_valid_q || out_ready;
   assign in_ready = !GlobalReset && (!s1_valid_q || s2_load);
   assign accept   = in_valid && in_ready;
   assign bank_ok  = (32'(cfg_sect) < 32'(NUM_SECT)) && (32'(cfg_word) < 32'(NUM_WORD));
   assign bnd_ok   = 32'(cfg_sect) < 32'(NUM_SECT - 1);

   always_comb begin
      bnd_d  = bnd_q;
      bank_d = bank_q;
      if (cfg_we && (cfg_sel == CFG_SEL_BND) && bnd_ok) begin
         bnd_d[cfg_sect] = cfg_data[X_W-1:0];
      end
      if (cfg_we && (cfg_sel == CFG_SEL_BANK) && bank_ok) begin
         bank_d[cfg_sect][cfg_word] = cfg_data;
      end
   end

   // S2 reads bank_q, so a same-cycle bank write lands after this read.
   always_comb begin
      s1_valid_d  = s1_valid_q && !s2_load;
      s1_x_d      = s1_x_q;
      s1_sect_d   = s1_sect_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_x_d     = x_in;
         s1_sect_d  = sect_w;
      end

      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      out_sect_d  = out_sect_q;
      out_coeff_d = out_coeff_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_x_d    = s1_x_q;
            out_sect_d = s1_sect_q;
            for (int w = 0; w < NUM_WORD; w++) begin
               out_coeff_d[w*COEFF_W +: COEFF_W] = bank_q[s1_sect_q][w];
            end
         end
      end

      sample_cnt_d = accept ? sample_cnt_q + 16'd1 : sample_cnt_q;
   end

   always_ff @(posedge Clock) begin
      if (GlobalReset) begin
         bnd_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_x_q       <= '0;
         s1_sect_q    <= '0;
         out_valid_q  <= 1'b0;
         out_x_q      <= '0;
         out_sect_q   <= '0;
         out_coeff_q  <= '0;
         sample_cnt_q <= '0;
         for (int s = 0; s < NUM_SECT; s++) begin
            for (int w = 0; w < NUM_WORD; w++) begin
               bank_q[s][w] <= '0;
            end
         end
      end else begin
         bnd_q        <= bnd_d;
         bank_q       <= bank_d;
         s1_valid_q   <= s1_valid_d;
         s1_x_q       <= s1_x_d;
         s1_sect_q    <= s1_sect_d;
         out_valid_q  <= out_valid_d;
         out_x_q      <= out_x_d;
         out_sect_q   <= out_sect_d;
         out_coeff_q  <= out_coeff_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_x      = out_x_q;
   assign out_sect   = out_sect_q;
   assign out_coeff  = out_coeff_q;
   assign sample_cnt = sample_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_section_select.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_section_select : self-checking bench for section_select
// Rev 1.0
// ============================================================================
module tb_section_select;
   import section_select_pkg::*;

   localparam int NS = 4;
   localparam int XW = 21;
   localparam int CW = 32;
   localparam int NW = 13;

   logic             Clock = 1'b0;
   logic             GlobalReset;
   logic             cfg_we;
   logic             cfg_sel;
   logic [1:0]       cfg_sect;
   logic [3:0]       cfg_word;
   logic [CW-1:0]    cfg_data;
   logic             in_valid;
   logic             in_ready;
   logic [XW-1:0]    x_in;
   logic             out_valid;
   logic             out_ready;
   logic [XW-1:0]    out_x;
   logic [1:0]       out_sect;
   logic [NW*CW-1:0] out_coeff;
   logic [15:0]      sample_cnt;

   always #5 Clock = ~Clock;

   section_select #(
      .NUM_SECT (NS),
      .X_W      (XW),
      .COEFF_W  (CW),
      .NUM_WORD (NW)
   ) dut (
      .Clock       (Clock),
      .GlobalReset (GlobalReset),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_sect    (cfg_sect),
      .cfg_word    (cfg_word),
      .cfg_data    (cfg_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x_in        (x_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_x       (out_x),
      .out_sect    (out_sect),
      .out_coeff   (out_coeff),
      .sample_cnt  (sample_cnt)
   );

   typedef struct {
      int x;
      int sect;
      int acc_cyc;
   } item_t;

   typedef struct {
      int x;
      int exp_sect;
   } vec_t;

   item_t       q[$];
   int          bnd_m [NS-1];
   logic [31:0] bank_m [NS][NW];
   int          cnt_m = 0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   bit          chk_coeff = 1'b1;
   bit          chk_lat = 1'b0;
   bit          last_acc = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sext(logic [31:0] d);
      int v;
      v = int'(d & ((32'd1 << XW) - 32'd1));
      if (v >= (1 << (XW - 1))) v = v - (1 << XW);
      return v;
   endfunction

   function automatic int ref_sect(int x);
      int n = 0;
      for (int i = 0; i < NS - 1; i++) if (x >= bnd_m[i]) n++;
      return n;
   endfunction

   // One clock of traffic: score the handshakes seen this cycle, then advance.
   task automatic step();
      item_t            it;
      bit               xfer;
      bit               stall;
      logic [XW-1:0]    hx;
      logic [1:0]       hs;
      logic [NW*CW-1:0] hc;
      #1;
      if (GlobalReset) check("in_ready_in_reset", in_ready, 0);
      else check("in_ready", in_ready, (q.size() < 2 || out_ready) ? 1 : 0);
      last_acc = !GlobalReset && in_valid && in_ready;
      xfer     = !GlobalReset && out_valid && out_ready;
      if (xfer) begin
         if (q.size() == 0) begin
            check("spurious_out_valid", out_valid, 0);
         end else begin
            it = q.pop_front();
            check("out_x", sext(32'(out_x)), it.x);
            check("out_sect", out_sect, it.sect);
            if (chk_coeff)
               for (int w = 0; w < NW; w++)
                  check("out_coeff", out_coeff[w*CW +: CW], bank_m[it.sect][w]);
            if (chk_lat) check("latency", cyc - it.acc_cyc, 2);
         end
      end
      if (last_acc) begin
         q.push_back('{x: sext(32'(x_in)), sect: ref_sect(sext(32'(x_in))), acc_cyc: cyc});
         cnt_m = (cnt_m + 1) % 65536;
      end
      stall = !GlobalReset && out_valid && !out_ready;
      hx = out_x;
      hs = out_sect;
      hc = out_coeff;
      if (GlobalReset) begin
         q.delete();
         cnt_m = 0;
         for (int i = 0; i < NS - 1; i++) bnd_m[i] = 0;
         for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) bank_m[s][w] = '0;
      end else if (cfg_we) begin
         if (cfg_sel) begin
            if (int'(cfg_sect) < NS - 1) bnd_m[cfg_sect] = sext(cfg_data);
         end else if (int'(cfg_word) < NW) begin
            bank_m[cfg_sect][cfg_word] = cfg_data;
         end
      end
      @(posedge Clock);
      cyc++;
      #1;
      check("sample_cnt", sample_cnt, cnt_m);
      if (stall) begin
         check("hold_valid", out_valid, 1);
         check("hold_x", out_x, hx);
         check("hold_sect", out_sect, hs);
         check("hold_coeff", (out_coeff === hc) ? 1 : 0, 1);
      end
   endtask

   task automatic cfg(bit sel, int s, int w, logic [31:0] d);
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_sect = 2'(s);
      cfg_word = 4'(w);
      cfg_data = d;
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic send(int xv);
      int n = 0;
      in_valid = 1'b1;
      x_in     = xv[XW-1:0];
      do begin
         step();
         n++;
      end while (!last_acc && n < 20);
      if (!last_acc) check("send_timeout", last_acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 10) begin
         step();
         n++;
      end
      check("wait_out_valid", out_valid, 1);
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (q.size() > 0 && n < 20) begin
         step();
         n++;
      end
      check("drain_empty", q.size(), 0);
   endtask

   initial begin
      vec_t tab [9];
      int   xs1 [4];
      int   xs3 [8];
      int   idx;

      tab[0] = '{513, 3};      tab[1] = '{1, 2};        tab[2] = '{-511, 1};
      tab[3] = '{-1023, 0};    tab[4] = '{512, 3};      tab[5] = '{511, 2};
      tab[6] = '{-512, 1};     tab[7] = '{-1048576, 0}; tab[8] = '{1048575, 3};
      xs1 = '{513, 1, -511, -1023};
      xs3 = '{700, -700, 10, -10, 600, -600, 300, -1};

      GlobalReset = 1'b1;
      cfg_we = 1'b0; cfg_sel = 1'b0; cfg_sect = '0; cfg_word = '0; cfg_data = '0;
      in_valid = 1'b0; x_in = '0; out_ready = 1'b0;
      step();
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_x", out_x, 0);
      check("rst_out_sect", out_sect, 0);
      check("rst_out_coeff", (out_coeff == '0) ? 1 : 0, 1);
      GlobalReset = 1'b0;

      cfg(1'b1, 0, 0, -512);
      cfg(1'b1, 1, 0, 0);
      cfg(1'b1, 2, 0, 512);
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) cfg(1'b0, s, w, 32'h200 + 32'(s));
      cfg(1'b0, 1, 14, 32'hFFFF_FFFF);
      cfg(1'b1, 3, 0, 32'h0000_0100);

      // Back-to-back stream: outputs on consecutive cycles, two cycles after each accept.
      out_ready = 1'b1;
      chk_lat   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         x_in     = xs1[i][XW-1:0];
         step();
         check("s1_accept", last_acc, 1);
      end
      drain();
      chk_lat = 1'b0;

      for (int i = 0; i < 9; i++) begin
         send(tab[i].x);
         wait_out();
         check("tab_x", sext(32'(out_x)), tab[i].x);
         check("tab_sect", out_sect, tab[i].exp_sect);
         check("tab_word0", out_coeff[CW-1:0], 32'h200 + 32'(tab[i].exp_sect));
         step();
      end

      idx = 0;
      for (int c = 0; c < 30 && (idx < 8 || q.size() > 0); c++) begin
         out_ready = !(c >= 2 && c < 7);
         in_valid  = (idx < 8);
         if (idx < 8) x_in = xs3[idx][XW-1:0];
         #1;
         if (c == 6) check("bp_in_ready_low", in_ready, 0);
         step();
         if (last_acc) idx++;
      end
      check("bp_all_in", idx, 8);
      check("bp_all_out", q.size(), 0);

      drain();
      chk_coeff = 1'b0;
      in_valid  = 1'b1;
      x_in      = 21'd100;
      step();
      x_in     = 21'd200;
      cfg_we   = 1'b1;
      cfg_sel  = 1'b0;
      cfg_sect = 2'd2;
      cfg_word = 4'(MEAN);
      cfg_data = 32'hDEAD;
      step();
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      check("s4_a_valid", out_valid, 1);
      check("s4_a_x", out_x, 100);
      check("s4_old_mean", out_coeff[MEAN*CW +: CW], 32'h202);
      step();
      check("s4_b_x", out_x, 200);
      check("s4_new_mean", out_coeff[MEAN*CW +: CW], 32'hDEAD);
      check("s4_b_std", out_coeff[STD*CW +: CW], 32'h202);
      step();
      chk_coeff = 1'b1;
      drain();

      // Bank writes here target only nonexistent words so in-flight reads stay deterministic.
      for (int c = 0; c < 800; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) x_in = 21'($urandom);
         else x_in = 21'($urandom_range(0, 2047)) - 21'd1024;
         out_ready = ($urandom_range(0, 2) != 0);
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_sel   = ($urandom_range(0, 3) != 0);
         cfg_sect  = 2'($urandom_range(0, 3));
         cfg_word  = 4'($urandom_range(13, 15));
         cfg_data  = {11'($urandom), 21'($urandom_range(0, 2047)) - 21'd1024};
         step();
      end
      cfg_we = 1'b0;
      drain();

      in_valid  = 1'b1;
      out_ready = 1'b0;
      x_in      = 21'd42;
      step();
      step();
      step();
      check("s5_full_in_ready", in_ready, 0);
      GlobalReset = 1'b1;
      step();
      check("s5_out_valid", out_valid, 0);
      check("s5_cnt", sample_cnt, 0);
      check("s5_coeff_zero", (out_coeff == '0) ? 1 : 0, 1);
      GlobalReset = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("s5_no_out", out_valid, 0);
         step();
      end
      send(5);
      wait_out();
      check("s5_sect", out_sect, 3);
      check("s5_bank_zero", (out_coeff == '0) ? 1 : 0, 1);
      step();

      GlobalReset = 1'b1;
      step();
      GlobalReset = 1'b0;
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      for (int i = 0; i < 65537; i++) begin
         x_in = 21'(i);
         step();
      end
      in_valid = 1'b0;
      check("wrap_cnt", sample_cnt, 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/section_select.md
SECTION_SELECT -- requirements
Module: section_select

Interface
REQ-001 Parameter NUM_SECT, default 4: number of piecewise sections; must be at least 2.
REQ-002 Parameter X_W, default 21: signed input sample width.
REQ-003 Parameter COEFF_W, default 32: width of each coefficient word.
REQ-004 Parameter NUM_WORD, default 13: words per section; 11 polynomial coefficients, then mean, then std.
REQ-005 Clock  in  1  single clock; all logic is posedge Clock.
REQ-006 GlobalReset  in  1  synchronous, active-high reset.
REQ-007 cfg_we  in  1  config write strobe.
REQ-008 cfg_sel  in  1  config target select: 0 = coefficient bank, 1 = boundary register.
REQ-009 cfg_sect  in  clog2(NUM_SECT)  section index (bank) or boundary index 0..NUM_SECT-2.
REQ-010 cfg_word  in  clog2(NUM_WORD)  word index within a section; ignored when cfg_sel=1.
REQ-011 cfg_data  in  COEFF_W  write data; the low X_W bits are used for a boundary write.
REQ-012 in_valid / in_ready  in / out  1  sample handshake.
REQ-013 x_in  in  X_W  signed sample.
REQ-014 out_valid / out_ready  out / in  1  result handshake.
REQ-015 out_x  out  X_W  sample passed through with its result.
REQ-016 out_sect  out  clog2(NUM_SECT)  selected section index.
REQ-017 out_coeff  out  NUM_WORD*COEFF_W  selected section's words; word 0 is in the LSBs.
REQ-018 sample_cnt  out  16  count of accepted samples; wraps modulo 2^16.

Function
REQ-019 Section rule: out_sect is the number of boundaries b[i] (i=0..NUM_SECT-2) with x >= b[i], compared signed; this rule holds even when boundaries are not in ascending order.
REQ-020 Pipeline has two stages.
- S1 (on accept): registers x and the computed section index.
- S2: registers x, the section index and that section's full word set into the outputs.
REQ-021 Latency is 2 cycles from the accept edge to out_valid with out_ready held high; throughput is 1 sample per cycle.
REQ-022 A transfer occurs on a cycle where valid and ready are both 1.
REQ-023 S2 loads when it is empty or when out_ready=1.
REQ-024 S1 advances to S2 whenever S2 loads.
REQ-025 in_ready = !S1_valid OR S2-load; it is combinational and has no dependency on in_valid.
REQ-026 While out_valid=1 and out_ready=0, out_x, out_sect and out_coeff are held stable.
REQ-027 Config write effects:
- A boundary write affects samples accepted on later cycles only.
- A sample accepted in the same cycle as the write uses the old boundary.
REQ-028 A bank write to the section being read into S2 in the same cycle yields the old word (read-before-write); later transfers see the new word.
REQ-029 Config writes are accepted every cycle regardless of handshake state.
REQ-030 Out-of-range cfg_sect or cfg_word writes are ignored.
REQ-031 sample_cnt increments by 1 on each in_valid&in_ready cycle and wraps from 0xFFFF to 0x0000.

Reset
REQ-032 While GlobalReset=1:
- out_valid=0, S1/S2 valid=0, in_ready=0.
- out_x=0, out_sect=0, out_coeff=0.
- sample_cnt=0.
- all boundaries=0 and all bank words=0.
REQ-033 Reset asserted mid-operation discards in-flight samples with no output transfer.
REQ-034 in_ready=1 on the first cycle after GlobalReset is released.

Structure
REQ-035 A shared package holds NUM_WORD, the word index constants (COEF0..COEF10, MEAN=11, STD=12) and the cfg_sel encodings.
REQ-036 The priority-free compare/count is a sub-module, section_index (combinational, X_W and NUM_SECT parameters); the bank and pipeline stay in section_select.

Verification
REQ-037 Scenario 1: NUM_SECT=4, boundaries -512, 0, 512; each bank word = section index + 0x200. Stream x = 513, 1, -511, -1023 back-to-back with out_ready=1 -> out_sect = 3, 2, 1, 0 on consecutive cycles, starting 2 cycles after the first accept; out_coeff words = 0x203, 0x202, 0x201, 0x200.
REQ-038 Scenario 2 (boundary edges): x = 512 -> 3; x = 511 -> 2; x = -512 -> 1; x = -2^20 -> 0; x = 2^20-1 -> 3.
REQ-039 Scenario 3 (backpressure): out_ready=0 for 5 cycles during a stream -> in_ready drops after 2 pending samples; outputs stay stable; no sample is lost or duplicated; order is preserved after release.
REQ-040 Scenario 4 (config during traffic): write bank section 2, word MEAN = 0xDEAD in the same cycle that a section-2 sample enters S2 -> that output carries the old mean; the next section-2 sample carries 0xDEAD.
REQ-041 Scenario 5 (reset mid-stream): GlobalReset asserted with both stages full -> out_valid=0, sample_cnt=0, all bank words read 0 afterwards.
REQ-042 Scenario 6 (counter wrap): accept 65537 samples -> sample_cnt = 1.
